// File: rtl/lif_sched_if.sv
// Bundles the lif_scheduler control, data and debug signals.
// The spike_total field exists only when LIF_SCHED_SPIKE_COUNT_EN is defined.
interface lif_sched_if #(
  parameter int N_NEURONS = 4,
  parameter int IN_W      = 4,
  parameter int POT_W     = 8
);
  localparam int SEL_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

  logic                      start;
  logic [N_NEURONS*IN_W-1:0] in_vec;
  logic [POT_W-1:0]          threshold;
  logic                      busy;
  logic                      done;
  logic [N_NEURONS-1:0]      spikes;
  logic [SEL_W-1:0]          pot_sel;
  logic [POT_W-1:0]          pot_out;
`ifdef LIF_SCHED_SPIKE_COUNT_EN
  logic [15:0]               spike_total;

  modport master (output start, in_vec, threshold, pot_sel,
                  input  busy, done, spikes, pot_out, spike_total);
  modport slave  (input  start, in_vec, threshold, pot_sel,
                  output busy, done, spikes, pot_out, spike_total);
`else
  modport master (output start, in_vec, threshold, pot_sel,
                  input  busy, done, spikes, pot_out);
  modport slave  (input  start, in_vec, threshold, pot_sel,
                  output busy, done, spikes, pot_out);
`endif
endinterface

// File: rtl/lif_scheduler.sv
// Time-multiplexed leaky-integrate-and-fire scheduler: one shared update datapath walks all neurons per timestep.
// Optional saturating spike counter enabled by defining LIF_SCHED_SPIKE_COUNT_EN.
module lif_scheduler #(
  parameter int N_NEURONS  = 4,
  parameter int IN_W       = 4,
  parameter int POT_W      = 8,
  parameter int LEAK_SHIFT = 2,
  parameter int REFRAC     = 2
) (
  input logic        clk,
  input logic        rst,
  lif_sched_if.slave bus
);
  localparam int SEL_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam int RW    = (REFRAC > 1) ? $clog2(REFRAC + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_WRITE, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [SEL_W-1:0]          idx_q, idx_d;
  logic [N_NEURONS*IN_W-1:0] in_vec_q, in_vec_d;
  logic [POT_W-1:0]          thr_q, thr_d;
  logic [POT_W-1:0]          sum_q, sum_d;
  logic                      refr_q, refr_d;
  logic [POT_W-1:0]          pot_q [N_NEURONS];
  logic [POT_W-1:0]          pot_d [N_NEURONS];
  logic [RW-1:0]             refrac_q [N_NEURONS];
  logic [RW-1:0]             refrac_d [N_NEURONS];
  logic [N_NEURONS-1:0]      spike_tmp_q, spike_tmp_d;
  logic [N_NEURONS-1:0]      spikes_q, spikes_d;
`ifdef LIF_SCHED_SPIKE_COUNT_EN
  logic [15:0]               count_q, count_d;
  logic [16:0]               count_ext;
  int                        pop;
`endif

  logic [POT_W-1:0] cur_pot;
  logic [POT_W-1:0] leak;
  logic [IN_W-1:0]  in_sel;
  logic [POT_W:0]   sum_ext;
  logic             fire;
  logic [N_NEURONS-1:0] tmp_next;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    in_vec_d    = in_vec_q;
    thr_d       = thr_q;
    sum_d       = sum_q;
    refr_d      = refr_q;
    pot_d       = pot_q;
    refrac_d    = refrac_q;
    spike_tmp_d = spike_tmp_q;
    spikes_d    = spikes_q;
`ifdef LIF_SCHED_SPIKE_COUNT_EN
    count_d     = count_q;
    count_ext   = '0;
    pop         = 0;
`endif
    cur_pot  = pot_q[idx_q];
    leak     = (LEAK_SHIFT >= POT_W) ? '0 : (cur_pot >> LEAK_SHIFT);
    in_sel   = in_vec_q[idx_q*IN_W +: IN_W];
    // leak never exceeds pot, so only the upper end can overflow
    sum_ext  = {1'b0, cur_pot} - {1'b0, leak} + (POT_W+1)'(in_sel);
    fire     = !refr_q && (thr_q != '0) && (sum_q >= thr_q);
    tmp_next = spike_tmp_q;
    tmp_next[idx_q] = fire;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          in_vec_d = bus.in_vec;
          thr_d    = bus.threshold;
          idx_d    = '0;
          state_d  = S_UPDATE;
        end
      end
      S_UPDATE: begin
        refr_d  = (refrac_q[idx_q] != '0);
        if (refrac_q[idx_q] != '0)
          sum_d = '0;
        else if (sum_ext[POT_W])
          sum_d = '1;
        else
          sum_d = sum_ext[POT_W-1:0];
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (fire) begin
          pot_d[idx_q]    = '0;
          refrac_d[idx_q] = RW'(REFRAC);
        end else begin
          pot_d[idx_q] = sum_q;
          if (refrac_q[idx_q] != '0)
            refrac_d[idx_q] = refrac_q[idx_q] - 1'b1;
        end
        // Publish on entry to DONE so spikes and done appear together
        if (idx_q == SEL_W'(N_NEURONS-1)) begin
          spikes_d    = tmp_next;
          spike_tmp_d = '0;
          state_d     = S_DONE;
`ifdef LIF_SCHED_SPIKE_COUNT_EN
          for (int i = 0; i < N_NEURONS; i++)
            pop = pop + int'(tmp_next[i]);
          count_ext = {1'b0, count_q} + 17'(pop);
          count_d   = count_ext[16] ? 16'hFFFF : count_ext[15:0];
`endif
        end else begin
          spike_tmp_d = tmp_next;
          idx_d       = idx_q + 1'b1;
          state_d     = S_UPDATE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      in_vec_q    <= '0;
      thr_q       <= '0;
      sum_q       <= '0;
      refr_q      <= 1'b0;
      spike_tmp_q <= '0;
      spikes_q    <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        pot_q[i]    <= '0;
        refrac_q[i] <= '0;
      end
`ifdef LIF_SCHED_SPIKE_COUNT_EN
      count_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      in_vec_q    <= in_vec_d;
      thr_q       <= thr_d;
      sum_q       <= sum_d;
      refr_q      <= refr_d;
      spike_tmp_q <= spike_tmp_d;
      spikes_q    <= spikes_d;
      pot_q       <= pot_d;
      refrac_q    <= refrac_d;
`ifdef LIF_SCHED_SPIKE_COUNT_EN
      count_q     <= count_d;
`endif
    end
  end

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = (state_q == S_DONE);
  assign bus.spikes  = spikes_q;
  assign bus.pot_out = pot_q[bus.pot_sel];
`ifdef LIF_SCHED_SPIKE_COUNT_EN
  assign bus.spike_total = count_q;
`endif
endmodule

// File: tb/tb_lif_scheduler.sv
// Directed-vector bench for lif_scheduler; a second instance with LEAK_SHIFT=8 covers saturation.
// Define LIF_SCHED_SPIKE_COUNT_EN to also check spike_total.
module tb_lif_scheduler;
  logic clk;
  logic rst;
  int   cycle_cnt;
  int   vec_count;
  int   err_count;
  int   done_cnt;
  int   done_cycs[$];
  int   start_cyc;
  int   latency;
  logic busy_at_accept;
  logic [7:0] pv;
  logic [7:0] pvs;

  lif_sched_if #(.N_NEURONS(4), .IN_W(4), .POT_W(8)) m_if ();
  lif_sched_if #(.N_NEURONS(4), .IN_W(4), .POT_W(8)) s_if ();

  lif_scheduler #(.N_NEURONS(4), .IN_W(4), .POT_W(8), .LEAK_SHIFT(2), .REFRAC(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (m_if.slave)
  );

  lif_scheduler #(.N_NEURONS(4), .IN_W(4), .POT_W(8), .LEAK_SHIFT(8), .REFRAC(2)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (s_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // done is sampled mid-cycle so every pulse is seen exactly once
  always @(negedge clk) begin
    if (m_if.done) begin
      done_cnt++;
      done_cycs.push_back(cycle_cnt);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      err_count++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic driveInputs(input logic [15:0] vec, input logic [7:0] thr, input logic st);
    m_if.in_vec = vec;  m_if.threshold = thr;  m_if.start = st;
    s_if.in_vec = vec;  s_if.threshold = thr;  s_if.start = st;
  endtask

  task automatic readPot(input int i, output logic [7:0] v, output logic [7:0] vs);
    m_if.pot_sel = 2'(i);
    s_if.pot_sel = 2'(i);
    #1;
    v  = m_if.pot_out;
    vs = s_if.pot_out;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    driveInputs(16'h0000, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One timestep; inputs are scrambled after acceptance to prove they were snapshotted
  task automatic applyStimulus(input logic [15:0] vec, input logic [7:0] thr);
    logic got;
    got = 1'b0;
    @(negedge clk);
    driveInputs(vec, thr, 1'b1);
    @(negedge clk);
    start_cyc      = cycle_cnt;
    busy_at_accept = m_if.busy;
    driveInputs(16'hFFFF, 8'h01, 1'b0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (m_if.done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) checkOutput("done_timeout", 32'd0, 32'd1);
    latency = cycle_cnt - start_cyc;
  endtask

  initial begin
    logic [3:0] exp_spk1 [6];
    logic [7:0] exp_leak [4];
    int         d0;
    exp_spk1 = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
    exp_leak = '{8'd8, 8'd14, 8'd19, 8'd23};
    cycle_cnt = 0; vec_count = 0; err_count = 0; done_cnt = 0;
    rst = 1'b1;
    m_if.pot_sel = '0;
    s_if.pot_sel = '0;
    driveInputs(16'h0000, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    $display("[TB] reset state");
    checkOutput("rst_busy", 32'(m_if.busy), 32'd0);
    checkOutput("rst_done", 32'(m_if.done), 32'd0);
    checkOutput("rst_spikes", 32'(m_if.spikes), 32'd0);

    $display("[TB] single fire and latency");
    applyStimulus(16'h000F, 8'd10);
    checkOutput("busy_after_start", 32'(busy_at_accept), 32'd1);
    // done lies in the cycle that ends at edge t+2N+1, i.e. 2N edges after acceptance
    checkOutput("done_latency", 32'(latency), 32'd8);
    checkOutput("fire_spikes", 32'(m_if.spikes), 32'b0001);
    for (int i = 0; i < 4; i++) begin
      readPot(i, pv, pvs);
      checkOutput($sformatf("fire_pot%0d", i), 32'(pv), 32'd0);
    end
    @(negedge clk);
    checkOutput("done_one_cycle", 32'(m_if.done), 32'd0);
    checkOutput("spikes_hold", 32'(m_if.spikes), 32'b0001);

    $display("[TB] leak");
    doReset();
    for (int s = 0; s < 4; s++) begin
      applyStimulus(16'h0008, 8'd200);
      readPot(0, pv, pvs);
      checkOutput($sformatf("leak_pot0_step%0d", s+1), 32'(pv), 32'(exp_leak[s]));
    end
    checkOutput("leak_spikes", 32'(m_if.spikes), 32'd0);

    $display("[TB] refractory");
    doReset();
    for (int s = 0; s < 6; s++) begin
      applyStimulus(16'h00F0, 8'd5);
      checkOutput($sformatf("refrac_spk_step%0d", s+1), 32'(m_if.spikes), 32'(exp_spk1[s]));
      if (s == 1 || s == 2) begin
        readPot(1, pv, pvs);
        checkOutput($sformatf("refrac_pot1_step%0d", s+1), 32'(pv), 32'd0);
      end
    end

    $display("[TB] saturation without leak");
    doReset();
    for (int s = 0; s < 18; s++) begin
      applyStimulus(16'h0F00, 8'd0);
      if (s == 16 || s == 17) begin
        readPot(2, pv, pvs);
        checkOutput($sformatf("sat_pot2_step%0d", s+1), 32'(pvs), 32'd255);
      end
    end
    checkOutput("sat_spikes", 32'(s_if.spikes), 32'd0);

    $display("[TB] reset mid-timestep");
    doReset();
    applyStimulus(16'h888F, 8'd10);
    checkOutput("pre_abort_spikes", 32'(m_if.spikes), 32'b0001);
    @(negedge clk);
    driveInputs(16'h888F, 8'd10, 1'b1);
    @(negedge clk);
    driveInputs(16'h888F, 8'd10, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt;
    checkOutput("abort_busy", 32'(m_if.busy), 32'd0);
    checkOutput("abort_done", 32'(m_if.done), 32'd0);
    checkOutput("abort_spikes", 32'(m_if.spikes), 32'd0);
    for (int i = 0; i < 4; i++) begin
      readPot(i, pv, pvs);
      checkOutput($sformatf("abort_pot%0d", i), 32'(pv), 32'd0);
    end
    repeat (15) @(negedge clk);
    checkOutput("abort_no_done", 32'(done_cnt - d0), 32'd0);

    $display("[TB] start held high");
    doReset();
    done_cycs.delete();
    @(negedge clk);
    driveInputs(16'h000F, 8'd10, 1'b1);
    repeat (20) @(negedge clk);
    driveInputs(16'h000F, 8'd10, 1'b0);
    repeat (15) @(negedge clk);
    checkOutput("held_done_count", 32'(done_cycs.size()), 32'd2);
    if (done_cycs.size() >= 2)
      checkOutput("held_spacing", 32'(done_cycs[1] - done_cycs[0]), 32'd10);

`ifdef LIF_SCHED_SPIKE_COUNT_EN
    $display("[TB] spike counter");
    doReset();
    checkOutput("count_reset", 32'(m_if.spike_total), 32'd0);
    for (int s = 0; s < 4; s++)
      applyStimulus(16'h000F, 8'd10);
    checkOutput("count_total", 32'(m_if.spike_total), 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end
endmodule
